// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED-sharing scheduler: FSM states, Gray code,
// one-hot decode and the round-robin winner search.
package led_sched_pkg;

    localparam int unsigned MaxReq  = 8;
    localparam int unsigned MaxBits = 32;

    typedef enum logic [1:0] {
        StIdle,
        StServe,
        StGap
    } state_e;

    function automatic logic [MaxBits-1:0] gray(input logic [MaxBits-1:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [MaxReq-1:0] onehot(input logic [2:0] idx);
        logic [MaxReq-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Descending scan so the smallest offset from last+1 is assigned last and wins;
    // offset nreq is the previous owner itself, which therefore ranks last.
    function automatic logic [2:0] rr_pick(input logic [MaxReq-1:0] req,
                                           input logic [2:0]        last,
                                           input int unsigned       nreq);
        logic [2:0]  win;
        int unsigned idx;
        win = last;
        for (int off = MaxReq; off >= 1; off--) begin
            if (off <= int'(nreq)) begin
                idx = (32'(last) + 32'(off)) % nreq;
                if (req[idx]) win = 3'(idx);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/led_share_sched_if.sv
// Bundle between the pattern sources (master) and the scheduler (slave).
interface led_share_sched_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned BITS = 5
);
    logic [NREQ-1:0]      req;
    logic [NREQ*BITS-1:0] pat;
    logic [NREQ-1:0]      gnt;
    logic [BITS-1:0]      led;
    logic                 busy;

    modport master (output req, output pat, input gnt, input led, input busy);
    modport slave  (input req, input pat, output gnt, output led, output busy);
endinterface

// File: rtl/led_tick_gen.sv
// Free-running prescaler; tick is high for the one cycle the count is all-ones.
module led_tick_gen #(
    parameter int unsigned LOG2DELAY = 21
) (
    input  logic clki,
    input  logic resetn,
    output logic tick
);

    logic [LOG2DELAY-1:0] cnt_q;

    always_ff @(posedge clki or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/led_share_sched.sv
// Round-robin time-sliced owner of the LED bank, with a blank gap between owners
// and a Gray-code idle display when nobody is asking.
module led_share_sched
    import led_sched_pkg::*;
#(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned BITS       = 5,
    parameter int unsigned LOG2DELAY  = 21,
    parameter int unsigned SLOT_TICKS = 4
) (
    input logic               clki,
    input logic               resetn,
    led_share_sched_if.slave  bus
);

    localparam int unsigned SlotW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam logic [SlotW-1:0] SlotLast = SlotW'(SLOT_TICKS - 1);

    state_e          state_q;
    logic [SlotW-1:0] slot_q;
    logic [BITS-1:0] cnt_q;
    logic [2:0]      last_q;
    logic [NREQ-1:0] gnt_q;
    logic [BITS-1:0] led_q;
    logic            busy_q;

    logic            tick;
    logic [2:0]      win;
    logic            any_req;
    logic            owner_req;
    logic            others_req;
    logic [BITS-1:0] owner_pat;
    logic [BITS-1:0] idle_led;

    led_tick_gen #(
        .LOG2DELAY (LOG2DELAY)
    ) u_tick_gen (
        .clki   (clki),
        .resetn (resetn),
        .tick   (tick)
    );

    always_comb begin
        win        = rr_pick(MaxReq'(bus.req), last_q, NREQ);
        any_req    = |bus.req;
        // gnt_q is the owner's one-hot while serving, so it doubles as the owner mask
        owner_req  = |(bus.req & gnt_q);
        others_req = |(bus.req & ~gnt_q);
        owner_pat  = bus.pat[32'(last_q)*BITS +: BITS];
        idle_led   = BITS'(gray(MaxBits'(cnt_q)));
    end

    always_ff @(posedge clki or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            slot_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 3'(NREQ - 1);
            gnt_q   <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    led_q <= idle_led;
                    if (tick) cnt_q <= cnt_q + 1'b1;
                    if (any_req) begin
                        last_q  <= win;
                        gnt_q   <= NREQ'(onehot(win));
                        slot_q  <= '0;
                        state_q <= StServe;
                        busy_q  <= 1'b1;
                    end
                end
                StServe: begin
                    led_q <= owner_pat;
                    if (!owner_req) begin
                        gnt_q   <= '0;
                        state_q <= StGap;
                    end else if (tick) begin
                        if (slot_q == SlotLast) begin
                            if (others_req) begin
                                gnt_q   <= '0;
                                state_q <= StGap;
                            end else begin
                                slot_q <= '0;
                            end
                        end else begin
                            slot_q <= slot_q + 1'b1;
                        end
                    end
                end
                StGap: begin
                    led_q <= '0;
                    if (tick) begin
                        if (any_req) begin
                            last_q  <= win;
                            gnt_q   <= NREQ'(onehot(win));
                            slot_q  <= '0;
                            state_q <= StServe;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.led  = led_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_led_share_sched.sv
// Randomized bench for led_share_sched against a cycle-level behavioural model.
module tb_led_share_sched;

    localparam int NReq      = 3;
    localparam int Bits      = 5;
    localparam int TickEvery = 4;
    localparam int SlotTicks = 2;

    logic clki   = 1'b0;
    logic resetn = 1'b0;
    always #5 clki = ~clki;

    led_share_sched_if #(.NREQ(NReq), .BITS(Bits)) bus ();

    led_share_sched #(
        .NREQ       (NReq),
        .BITS       (Bits),
        .LOG2DELAY  (2),
        .SLOT_TICKS (SlotTicks)
    ) dut (
        .clki   (clki),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 serving, 2 gap
    logic [NReq-1:0] req_v;
    logic [Bits-1:0] pat_a [NReq];
    int              m_mode, m_pc, m_cnt, m_last, m_slot;
    logic [NReq-1:0] m_gnt;
    logic [Bits-1:0] m_led;

    task automatic drive();
        bus.req = req_v;
        for (int i = 0; i < NReq; i++) bus.pat[i*Bits +: Bits] = pat_a[i];
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_cnt = 0; m_last = NReq - 1; m_slot = 0;
        m_gnt = '0; m_led = '0;
    endtask

    function automatic int pick();
        for (int off = 1; off <= NReq; off++) begin
            if (req_v[(m_last + off) % NReq]) return (m_last + off) % NReq;
        end
        return -1;
    endfunction

    task automatic grant();
        m_last = pick();
        m_gnt  = NReq'(1 << m_last);
        m_slot = 0;
        m_mode = 1;
    endtask

    task automatic model_step();
        bit tick;
        tick = (m_pc == TickEvery - 1);
        m_pc = (m_pc + 1) % TickEvery;
        case (m_mode)
            0: begin
                m_led = Bits'(m_cnt ^ (m_cnt >> 1));
                if (tick) m_cnt = (m_cnt + 1) % (1 << Bits);
                if (req_v != 0) grant();
            end
            1: begin
                m_led = pat_a[m_last];
                if (!req_v[m_last]) begin
                    m_gnt = '0; m_mode = 2;
                end else if (tick) begin
                    if (m_slot == SlotTicks - 1) begin
                        if ((req_v & ~NReq'(1 << m_last)) != 0) begin
                            m_gnt = '0; m_mode = 2;
                        end else m_slot = 0;
                    end else m_slot++;
                end
            end
            default: begin
                m_led = '0;
                if (tick) begin
                    if (req_v != 0) grant();
                    else m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic cycle();
        @(posedge clki);
        model_step();
        @(negedge clki);
        check_eq("gnt", 32'(bus.gnt), 32'(m_gnt));
        check_eq("led", 32'(bus.led), 32'(m_led));
        check_eq("busy", 32'(bus.busy), 32'(m_mode != 0));
    endtask

    // Called just after a falling edge: assert reset between edges, release at next fall
    task automatic do_reset();
        #2 resetn = 1'b0;
        #1;
        check_eq("rst_gnt", 32'(bus.gnt), 32'h0);
        check_eq("rst_led", 32'(bus.led), 32'h0);
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        model_reset();
        @(posedge clki);
        @(negedge clki);
        resetn = 1'b1;
    endtask

    logic [Bits-1:0] idle_tbl [6] = '{5'h00, 5'h01, 5'h03, 5'h02, 5'h06, 5'h07};

    initial begin
        int n;
        req_v = '0;
        for (int i = 0; i < NReq; i++) pat_a[i] = '0;
        drive();
        model_reset();
        repeat (2) @(negedge clki);
        resetn = 1'b1;

        // Idle Gray count: after edge 4k+1 the led shows gray(k)
        for (int c = 1; c <= 24; c++) begin
            cycle();
            if ((c - 1) % TickEvery == 0)
                check_eq("idle_seq", 32'(bus.led), 32'(idle_tbl[(c - 1) / TickEvery]));
        end

        // Single owner renewing through several slot expiries
        req_v = 3'b010; pat_a[1] = 5'h15; drive();
        cycle();
        check_eq("single_gnt", 32'(bus.gnt), 32'h2);
        for (int c = 0; c < 30; c++) begin
            cycle();
            check_eq("single_hold_gnt", 32'(bus.gnt), 32'h2);
            check_eq("single_hold_led", 32'(bus.led), 32'h15);
        end

        // Contention between req0 and req2
        req_v = 3'b101; pat_a[0] = 5'h01; pat_a[2] = 5'h1F; drive();
        for (int c = 0; c < 40; c++) cycle();

        // Reset while req2 owns; first winner afterwards must be req0
        n = 0;
        while (m_gnt != 3'b100 && n < 40) begin
            cycle();
            n++;
        end
        check_eq("reach_gnt100", 32'(bus.gnt), 32'h4);
        req_v = 3'b111; drive();
        do_reset();
        cycle();
        check_eq("post_rst_winner", 32'(bus.gnt), 32'h1);

        // Random requests, patterns and occasional async resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NReq; i++) begin
                if ($urandom_range(7) == 0) req_v[i] = ~req_v[i];
                pat_a[i] = Bits'($urandom);
            end
            drive();
            if ($urandom_range(399) == 0) do_reset();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_share_sched.md
Name: led_share_sched

Overview:
- Time-sliced scheduler that shares the 5-bit LED bank between several requesters.
- Each requester drives its own LED pattern. The block grants the bank round-robin, in slots measured in prescaler ticks.
- A one-tick blank gap separates successive owners.
- With no requester active, it displays a free-running Gray-code idle count.
- Sits between top-level pattern sources and the led pins.

Parameters:
- NREQ, 3: number of requesters (2..8).
- BITS, 5: LED width.
- LOG2DELAY, 21: prescaler width. One tick every 2^LOG2DELAY cycles. Minimum 1.
- SLOT_TICKS, 4: ticks per grant slot before rotation. Minimum 1.

Ports:
- clki  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester level request; held while owning
- pat  in  NREQ*BITS  requester patterns; requester i at [i*BITS +: BITS]
- gnt  out  NREQ  registered one-hot grant; all-zero when no owner
- led  out  BITS  registered LED drive
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, prescaler=0, slot=0, idle count=0, last-owner pointer=NREQ-1 (first winner is req0), gnt=0, led=0, busy=0. Reset mid-slot aborts the grant immediately.
- Prescaler: LOG2DELAY-bit up-counter, wraps naturally. tick=1 exactly in the cycle the count is all-ones.
- Round-robin pick: search from last+1 mod NREQ upward, wrapping; first asserted req wins. The winner becomes the new last.
- IDLE:
  - gnt=0.
  - idle count (BITS wide, wraps) increments on each tick.
  - led <= cnt ^ (cnt>>1).
  - Any req high at an edge: pick winner, gnt <= onehot(winner), slot <= 0, go SERVE. This is not tick-aligned.
- SERVE:
  - led <= pat[owner] every cycle, so led lags pat by 1 cycle. The first owner pattern appears 1 edge after gnt rises.
  - slot increments on tick.
  - req[owner]=0 at an edge: gnt <= 0, go GAP (release). Release takes priority over slot expiry.
  - tick with slot==SLOT_TICKS-1:
    - If any other req is high: gnt <= 0, go GAP.
    - Otherwise slot <= 0 and stay (renew). gnt remains unchanged with no glitch.
- GAP:
  - gnt=0, led <= 0.
  - Wait for next tick; the tick that caused entry does not count.
  - On that tick: if any req is high, pick winner, go SERVE. Otherwise go IDLE; the idle count resumes from its held value.
  - A former owner is eligible again but ranks last under round-robin.
- pat of non-owners is ignored. req changes in GAP only matter at the exit tick.
- The idle count freezes outside IDLE.
- gnt is never multi-hot. gnt and led change only on clki edges or async reset.

Decomposition:
- Shared package led_sched_pkg:
  - state enum (IDLE, SERVE, GAP)
  - gray(x) function
  - onehot(idx) function
- One sub-module: led_tick_gen (prescaler).
  - Params: LOG2DELAY.
  - Ports: clki, resetn, tick.
- The round-robin pick stays in-line as a function in the package.

Test Plan:
Bench parameters: LOG2DELAY=2 (tick every 4 cycles), SLOT_TICKS=2, NREQ=3, BITS=5.
1. Idle: no req, 6 ticks -> led steps 00000,00001,00011,00010,00110,00111; gnt=000; busy=0.
2. Single owner: req=010, pat1=5'h15 -> gnt=010 next edge, led=5'h15 one edge later. Holds through 3 slot expiries (renew): gnt stays 010 and led never blanks.
3. Contention: req=101, pat0=5'h01, pat2=5'h1F -> sequence gnt 001 (2 ticks), GAP led=0 for one tick, gnt 100 (2 ticks), GAP, 001. led alternates 01/00/1F/00.
4. Release mid-slot: owner req0 drops 1 cycle after the first tick, others idle -> gnt=000 next edge, led=0 until next tick, then IDLE resumes Gray count from its frozen value.
5. Async reset mid-SERVE: resetn low between edges while gnt=100 -> gnt, led, busy = 0 immediately. After release with req=111, first winner is req0 (gnt=001).
6. Late arrival in GAP: req0 owner expires with req1 pending; req1 drops and req2 rises inside GAP -> exit tick grants 100.
